pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
Program-counter stage downstream of the branch-decision gate. It consumes PCSrc (Branch & Zero), the Jump control and the instruction immediates. It computes the next PC (sequential, branch target or jump target) and holds it in the PC register that drives instruction memory. A small FSM handles post-reset boot hold, stall and halt.

Parameters:
WIDTH, 32, datapath/PC width in bits (WIDTH >= 28 required)
RESET_PC, 32'h0000_0000, PC value loaded on reset
BOOT_CYCLES, 2, cycles PC is held at RESET_PC after reset release before the first advance (>= 1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
PCSrc  input  1  branch taken (Branch & Zero)
Jump  input  1  j-type jump taken
SignImm  input  WIDTH  sign-extended 16-bit immediate
Instr_Index  input  26  instruction bits [25:0]
Stall  input  1  hold PC this cycle
Halt  input  1  halt request (decoded halt instruction)
PC  output  WIDTH  current PC to instruction memory
PCPlus4  output  WIDTH  PC + 4, combinational from PC
Fetch_Valid  output  1  PC holds a real fetch address this cycle
Halted  output  1  FSM is in HALT

Behaviour:
- Reset: clk and rst_n only; one clock, asynchronous active-low reset. While rst_n = 0: PC = RESET_PC, state = BOOT, boot counter = 0, Fetch_Valid = 0, Halted = 0. Reset asserted mid-operation takes effect immediately, regardless of clk.
- Arithmetic, all modulo 2^WIDTH (wrap silently, no flag):
  - PCPlus4 = PC + 4.
  - PCBranch = PCPlus4 + (SignImm << 2).
  - PCJump = {PCPlus4[WIDTH-1:28], Instr_Index, 2'b00}.
- Next-PC priority (RUN only): Jump > PCSrc > sequential.
  - Jump = 1 -> PCJump.
  - Else PCSrc = 1 -> PCBranch.
  - Else PCPlus4.
  - Jump and PCSrc both 1 -> Jump wins.
- FSM states: BOOT, RUN, HALT.
  - BOOT:
    - PC held at RESET_PC, Fetch_Valid = 0, inputs ignored.
    - Counter increments each cycle.
    - Counter = BOOT_CYCLES-1 -> RUN next cycle. PC is still RESET_PC on the first RUN cycle.
  - RUN:
    - Fetch_Valid = 1.
    - Stall = 1 -> PC unchanged; PCSrc/Jump/Halt ignored that cycle.
    - Stall = 0 and Halt = 1 -> PC unchanged, go to HALT. Halt beats Jump/PCSrc.
    - Otherwise PC <= next-PC, latency 1 cycle (new PC visible after the rising edge).
  - HALT:
    - PC frozen, Fetch_Valid = 0, Halted = 1.
    - Only reset exits HALT.
- Outputs PC, Fetch_Valid and Halted are registered/state-decoded. PCPlus4 is combinational from PC.
- No X propagation: unknown Jump/PCSrc in BOOT/HALT must not affect PC.

Decomposition:
- Shared package/header: state encoding localparams ST_BOOT = 2'd0, ST_RUN = 2'd1, ST_HALT = 2'd2; constant PC_INCR = 4.
- One natural sub-module, pc_target_calc (combinational): produces PCPlus4, PCBranch, PCJump.
- Register, FSM and priority mux stay in pc_next_unit.

Test Plan:
1. Reset then run, BOOT_CYCLES = 2, no controls.
   - PC = 0 for reset plus 2 boot cycles with Fetch_Valid = 0.
   - Then Fetch_Valid = 1; PC steps 0 -> 4 -> 8 -> 0xC on successive edges.
2. Branch at PC = 0x10: PCSrc = 1, SignImm = 0xFFFF_FFFC (-4).
   - Next PC = 0x14 + (-16) = 0x04.
   - With SignImm = 3: next PC = 0x20.
3. Jump at PC = 0x1000_0010, Instr_Index = 0x000_0040.
   - Next PC = 0x1000_0100.
   - Jump = 1 with PCSrc = 1 also gives 0x1000_0100.
4. Stall priority: PC = 0x20, Stall = 1 for 3 cycles with Jump = 1.
   - PC stays 0x20 for all 3 cycles.
   - Stall drops with Jump = 0 -> 0x24.
5. Halt and wrap:
   - PC = 0xFFFF_FFFC, no controls -> PC = 0x0000_0000.
   - Then Halt = 1 -> PC frozen at 0, Halted = 1, Fetch_Valid = 0, Jump ignored.
6. Async reset: drive rst_n low mid-cycle while in RUN at PC = 0x48.
   - PC = RESET_PC and Fetch_Valid = 0 immediately, before the next clk edge.
   - BOOT hold repeats after release.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared definitions for the program-counter stage: the FSM state encoding
// and the sequential fetch increment.
package pc_next_unit_pkg;

    // PC-stage control states. The encoding is fixed so that state values
    // seen on a waveform match the documented values.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // Byte distance between consecutive instruction words.
    localparam int PC_INCR = 4;

endpackage : pc_next_unit_pkg

// File: rtl/pc_next_unit_target_calc.sv
// Combinational next-PC candidates: sequential (PC+4), PC-relative branch
// target and pseudo-direct jump target. All sums wrap modulo 2^WIDTH.
module pc_target_calc
    import pc_next_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] sign_imm,
    input  logic [25:0]      instr_index,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] pc_branch,
    output logic [WIDTH-1:0] pc_jump
);

    localparam logic [WIDTH-1:0] INCR = WIDTH'(PC_INCR);

    // Sequential address and word-scaled branch offset
    always_comb begin
        pc_plus4  = pc + INCR;
        pc_branch = pc_plus4 + (sign_imm << 2);
    end

    // The jump target keeps the top bits of PC+4 above bit 27; with a
    // 28-bit datapath there are no such bits and the index fills the PC.
    generate
        if (WIDTH > 28) begin : g_jump_wide
            assign pc_jump = {pc_plus4[WIDTH-1:28], instr_index, 2'b00};
        end else begin : g_jump_narrow
            assign pc_jump = {instr_index, 2'b00};
        end
    endgenerate

endmodule : pc_target_calc

// File: rtl/pc_next_unit.sv
// Program-counter register with boot hold, stall and halt control.
// The PC register drives instruction memory; PCPlus4 is combinational from it.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int               WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_PC    = '0,
    parameter int               BOOT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PCSrc,
    input  logic             Jump,
    input  logic [WIDTH-1:0] SignImm,
    input  logic [25:0]      Instr_Index,
    input  logic             Stall,
    input  logic             Halt,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             Fetch_Valid,
    output logic             Halted
);

    // Counter only needs to reach BOOT_CYCLES-1.
    localparam int               CNT_W     = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

    pc_state_e        state_reg, state_next;
    logic [CNT_W-1:0] boot_cnt_reg, boot_cnt_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] pc_plus4, pc_branch, pc_jump, pc_sel;

    pc_target_calc #(
        .WIDTH(WIDTH)
    ) u_target_calc (
        .pc          (pc_reg),
        .sign_imm    (SignImm),
        .instr_index (Instr_Index),
        .pc_plus4    (pc_plus4),
        .pc_branch   (pc_branch),
        .pc_jump     (pc_jump)
    );

    // Redirect priority: jump over taken branch over sequential
    always_comb begin
        pc_sel = pc_plus4;
        if (Jump) begin
            pc_sel = pc_jump;
        end else if (PCSrc) begin
            pc_sel = pc_branch;
        end
    end

    // State, boot counter and PC registers; reset acts without a clock edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_BOOT;
            boot_cnt_reg <= '0;
            pc_reg       <= RESET_PC;
        end else begin
            state_reg    <= state_next;
            boot_cnt_reg <= boot_cnt_next;
            pc_reg       <= pc_next;
        end
    end

    // Next-state and next-PC. Outside RUN the redirect mux is never
    // selected, so unknown control inputs cannot reach the PC.
    always_comb begin
        state_next    = state_reg;
        boot_cnt_next = boot_cnt_reg;
        pc_next       = pc_reg;
        unique case (state_reg)
            ST_BOOT: begin
                if (boot_cnt_reg == BOOT_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (Stall) begin
                    pc_next = pc_reg;
                end else if (Halt) begin
                    state_next = ST_HALT;
                end else begin
                    pc_next = pc_sel;
                end
            end
            ST_HALT: begin
                state_next = ST_HALT;
            end
            default: begin
                // Unreachable encoding: restart through the boot hold.
                state_next    = ST_BOOT;
                boot_cnt_next = '0;
                pc_next       = RESET_PC;
            end
        endcase
    end

    assign PC          = pc_reg;
    assign PCPlus4     = pc_plus4;
    assign Fetch_Valid = (state_reg == ST_RUN);
    assign Halted      = (state_reg == ST_HALT);

endmodule : pc_next_unit

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios followed by
// randomized control traffic, all checked against a cycle reference model.
module tb_pc_next_unit;

    localparam int          WIDTH       = 32;
    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam int          BOOT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCSrc, Jump, Stall, Halt;
    logic [31:0] SignImm;
    logic [25:0] Instr_Index;
    logic [31:0] PC, PCPlus4;
    logic        Fetch_Valid, Halted;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: address in bytes, boot cycles still to wait, halted flag.
    logic [31:0] m_pc;
    int          m_boot_left;
    bit          m_halted;

    pc_next_unit #(
        .WIDTH       (WIDTH),
        .RESET_PC    (RESET_PC),
        .BOOT_CYCLES (BOOT_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .PCSrc       (PCSrc),
        .Jump        (Jump),
        .SignImm     (SignImm),
        .Instr_Index (Instr_Index),
        .Stall       (Stall),
        .Halt        (Halt),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .Fetch_Valid (Fetch_Valid),
        .Halted      (Halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},      PC,                   m_pc);
        check({tag, ".pcplus4"}, PCPlus4,              m_pc + 32'd4);
        check({tag, ".valid"},   {31'd0, Fetch_Valid}, {31'd0, (m_boot_left == 0 && !m_halted)});
        check({tag, ".halted"},  {31'd0, Halted},      {31'd0, m_halted});
    endtask

    function automatic void model_reset();
        m_pc        = RESET_PC;
        m_boot_left = BOOT_CYCLES;
        m_halted    = 1'b0;
    endfunction

    // Holds reset for two edges (called just after a falling edge or mid-cycle
    // with rst_n already low), checking that nothing moves, then releases it.
    task automatic hold_reset();
        model_reset();
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("rst.pc",     PC,                   RESET_PC);
            check("rst.valid",  {31'd0, Fetch_Valid}, 32'd0);
            check("rst.halted", {31'd0, Halted},      32'd0);
        end
        rst_n = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        hold_reset();
    endtask

    // One clock: drive controls, let the edge pass, advance the model, check.
    task automatic cycle(input bit st, input bit hl, input bit jp, input bit br,
                         input logic [31:0] imm, input logic [25:0] idx);
        logic [31:0] seq;
        Stall = st; Halt = hl; Jump = jp; PCSrc = br;
        SignImm = imm; Instr_Index = idx;
        @(posedge clk);
        seq = m_pc + 32'd4;
        if (m_halted) begin
            // frozen until reset
        end else if (m_boot_left > 0) begin
            m_boot_left--;
        end else if (st) begin
            // PC held
        end else if (hl) begin
            m_halted = 1'b1;
        end else if (jp) begin
            m_pc = {seq[31:28], idx, 2'b00};
        end else if (br) begin
            m_pc = seq + imm * 32'd4;
        end else begin
            m_pc = seq;
        end
        @(negedge clk);
        check_all("cyc");
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 26'd0);
    endtask

    // Steer the PC to an aligned target with a single taken branch.
    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] diff;
        diff = target - m_pc - 32'd4;
        cycle(1'b0, 1'b0, 1'b0, 1'b1, {{2{diff[31]}}, diff[31:2]}, 26'd0);
        check("goto", PC, target);
    endtask

    initial begin
        rst_n = 1'b0;
        PCSrc = 1'b0; Jump = 1'b0; Stall = 1'b0; Halt = 1'b0;
        SignImm = '0; Instr_Index = '0;
        @(negedge clk);

        // 1: reset, boot hold, then sequential fetch
        hold_reset();
        idle();
        check("boot1.valid", {31'd0, Fetch_Valid}, 32'd0);
        idle();
        check("boot2.pc",    PC, 32'h0);
        check("boot2.valid", {31'd0, Fetch_Valid}, 32'd1);
        idle(); check("seq.4", PC, 32'h4);
        idle(); check("seq.8", PC, 32'h8);
        idle(); check("seq.c", PC, 32'hC);

        // 2: branches backward and forward from 0x10
        goto_pc(32'h10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 26'd0);
        check("br.neg", PC, 32'h04);
        goto_pc(32'h10);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'h3, 26'd0);
        check("br.pos", PC, 32'h20);

        // 3: jump, alone and against a taken branch
        goto_pc(32'h1000_0010);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 26'h40);
        check("jmp", PC, 32'h1000_0100);
        goto_pc(32'h1000_0010);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h123, 26'h40);
        check("jmp.over.br", PC, 32'h1000_0100);

        // 4: stall beats jump
        goto_pc(32'h20);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 26'h3FF);
            check("stall", PC, 32'h20);
        end
        idle();
        check("stall.release", PC, 32'h24);

        // 6: asynchronous reset in the middle of a cycle
        goto_pc(32'h48);
        #2 rst_n = 1'b0;
        #1;
        check("arst.pc",    PC,                   RESET_PC);
        check("arst.valid", {31'd0, Fetch_Valid}, 32'd0);
        hold_reset();
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'h55, 26'h2AA);
        check("arst.boot1.pc", PC, RESET_PC);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h155);
        check("arst.boot2.pc", PC, RESET_PC);
        check("arst.boot2.valid", {31'd0, Fetch_Valid}, 32'd1);

        // Randomized traffic, including halts recovered by reset
        for (int n = 0; n < 400; n++) begin
            if (m_halted && ($urandom_range(0, 3) == 0)) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                      $urandom, 26'($urandom));
            end
        end
        if (m_halted) do_reset();
        while (m_boot_left > 0) idle();

        // 5: wrap at the top of the address space, then halt
        goto_pc(32'hFFFF_FFFC);
        idle();
        check("wrap", PC, 32'h0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'h7, 26'h10);
        check("halt.pc",     PC,                   32'h0);
        check("halt.halted", {31'd0, Halted},      32'd1);
        check("halt.valid",  {31'd0, Fetch_Valid}, 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 26'h3FFFFFF);
        check("halt.jump.ignored", PC, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_pc_next_unit
